// File: rtl/main_ctrl_seq.sv
// -----------------------------------------------------------------------------
// main_ctrl_seq
//
// Main-control sequencer for the EDSAC control section. It walks NSTAGES
// one-hot stages, from fetch (stage 0) to execute (stage NSTAGES-1). Each stage
// must dwell for HOLD_PI pulse intervals before an r_pulse coincidence may
// hand off to the next stage. The block also carries the sequence control
// tank (SCT) counter, with its increment gating and stop-one suppression.
//
// Parameters
//   NSTAGES  number of main-control stages (>= 2)
//   HOLD_PI  minimum dwell, in cycles, before a stage is armed (>= 1)
//   NSTOP    number of stop-one request inputs
//   SCT_W    SCT counter width
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   ep            combined end pulse (level); its rising edge is an ep event
//   single_ep     single-shot start pulse
//   stop_neg      low = stop after the current order
//   r_pulse       coincidence strobe from timing
//   d0            digit-0 timing pulse
//   eng_mode_neg  low = engineering mode, SCT increment inhibited
//   stop_one      stop-one requests (ORed together)
//   sct_load      load the SCT (transfer order)
//   sct_load_val  value loaded into the SCT
//   stage         one-hot current stage; all-zero means idle
//   busy          any stage active
//   r_coinc       coincidence in the last stage while armed
//   s_pulse       per-stage start pulse aligned to d0
//   sct_one       SCT increment strobe
//   sct_q         SCT value
//   ep_done       one-cycle pulse the cycle after ep falls
//   ep_err        sticky flag: an ep event arrived in a non-last stage
// -----------------------------------------------------------------------------
module main_ctrl_seq #(
  parameter int NSTAGES = 2,
  parameter int HOLD_PI = 1,
  parameter int NSTOP   = 3,
  parameter int SCT_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ep,
  input  logic               single_ep,
  input  logic               stop_neg,
  input  logic               r_pulse,
  input  logic               d0,
  input  logic               eng_mode_neg,
  input  logic [NSTOP-1:0]   stop_one,
  input  logic               sct_load,
  input  logic [SCT_W-1:0]   sct_load_val,
  output logic [NSTAGES-1:0] stage,
  output logic               busy,
  output logic               r_coinc,
  output logic [NSTAGES-1:0] s_pulse,
  output logic               sct_one,
  output logic [SCT_W-1:0]   sct_q,
  output logic               ep_done,
  output logic               ep_err
);

  localparam int DW = (HOLD_PI < 1) ? 1 : $clog2(HOLD_PI + 1);
  localparam logic [DW-1:0]      HOLD_V = DW'(HOLD_PI);
  localparam logic [NSTAGES-1:0] IDLE   = '0;
  localparam logic [NSTAGES-1:0] FETCH  = NSTAGES'(1);

  // Dwell count saturates once the stage is armed.
  function automatic logic [DW-1:0] dwell_sat_inc(input logic [DW-1:0] d);
    return (d == HOLD_V) ? d : d + DW'(1);
  endfunction

  // SCT increment wraps modulo 2^SCT_W.
  function automatic logic [SCT_W-1:0] sct_wrap_inc(input logic [SCT_W-1:0] q);
    return q + SCT_W'(1);
  endfunction

  logic               ep_p1;
  logic [DW-1:0]      dwell;
  logic [NSTAGES-1:0] arm;
  logic               stop_lat;

  logic               ep_evt;
  logic               ep_fall;
  logic               go;
  logic               last;
  logic               armed;
  logic               entry;
  logic [NSTAGES-1:0] stage_nxt;

  // ---- stage p0: edge detect and combinational decode ----
  assign ep_evt  = ep & ~ep_p1;
  assign ep_fall = ~ep & ep_p1;
  assign go      = (ep_evt & stop_neg) | single_ep;
  assign last    = stage[NSTAGES-1];
  assign armed   = (dwell == HOLD_V);
  assign busy    = |stage;

  always_comb begin
    stage_nxt = stage;
    if (!busy) begin
      if (go) stage_nxt = FETCH;
    end else if (!last) begin
      // ep events never move a non-last stage; only an armed coincidence does.
      if (armed && r_pulse) stage_nxt = stage << 1;
    end else begin
      if (single_ep || (ep_evt && stop_neg)) stage_nxt = FETCH;
      else if (ep_evt)                       stage_nxt = IDLE;
    end
  end

  // Any change to a non-idle stage (including last -> fetch) is an entry.
  assign entry = (stage_nxt != stage) && (stage_nxt != IDLE);

  assign r_coinc = last & armed & r_pulse;

  // The start pulse needs at least one dwell cycle, so the entry cycle never fires.
  assign s_pulse = (d0 && (dwell != '0)) ? (arm & stage) : IDLE;

  // Same-cycle single_ep and ep event still yield at most one increment,
  // because the strobe depends only on the ep edge.
  assign sct_one = ep_evt & ~stop_lat & ~(|stop_one) & eng_mode_neg;

  // ---- stage p1: registered state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ep_p1    <= 1'b0;
      stage    <= IDLE;
      dwell    <= '0;
      arm      <= IDLE;
      stop_lat <= 1'b0;
      ep_done  <= 1'b0;
      ep_err   <= 1'b0;
      sct_q    <= '0;
    end else begin
      ep_p1   <= ep;
      stage   <= stage_nxt;
      ep_done <= ep_fall;
      ep_err  <= ep_err | (ep_evt & busy & ~last);

      if (entry || (stage_nxt == IDLE)) dwell <= '0;
      else                              dwell <= dwell_sat_inc(dwell);

      // A stage exit drops any start pulse still pending for the old stage.
      if (entry)                   arm <= stage_nxt;
      else if (stage_nxt == IDLE)  arm <= IDLE;
      else                         arm <= arm & ~s_pulse;

      // A new stop request beats a same-cycle clear.
      if (|stop_one)     stop_lat <= 1'b1;
      else if (ep_done)  stop_lat <= 1'b0;

      if (sct_load)      sct_q <= sct_load_val;
      else if (sct_one)  sct_q <= sct_wrap_inc(sct_q);
    end
  end

endmodule
